// File: rtl/seg_scan4.sv
// ============================================================================
// seg_scan4 : four-digit multiplexed seven-segment driver with frame snapshot
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan4 #(
  parameter int CLK_DIV = 100000
) (
  input  logic        System_clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_en,
  input  logic        en,
  output logic [3:0]  ano,
  output logic [6:0]  leds,
  output logic        dp,
  output logic        frame_done
);

  localparam int             DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_idx;
  logic [19:0]      r_snap;
  logic             r_run;
  logic [3:0]       r_ano;
  logic [6:0]       r_leds;
  logic             r_dp;
  logic             r_frame_done;

  logic             w_tick;
  logic             w_load;
  logic [19:0]      w_src;
  logic [1:0]       w_next_idx;
  logic [3:0]       w_digit;
  logic [3:0]       w_lz;
  logic [3:0]       w_dp_bits;
  logic [6:0]       w_seg;
  logic             w_dp;

  function automatic logic [6:0] decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  always_comb begin
    w_tick     = (r_div_cnt == DIV_LAST);
    w_load     = w_tick && (r_idx == 2'd3);
    // The frame's first digit is drawn from the data being captured this edge.
    w_src      = w_load ? {dp_in, digits} : r_snap;
    w_next_idx = r_idx + 2'd1;
    w_dp_bits  = w_src[19:16];
    w_digit    = 4'h0;
    case (w_next_idx)
      2'd0: w_digit = w_src[3:0];
      2'd1: w_digit = w_src[7:4];
      2'd2: w_digit = w_src[11:8];
      2'd3: w_digit = w_src[15:12];
      default: w_digit = 4'h0;
    endcase
    w_lz[3] = blank_en && (w_src[15:12] == 4'h0);
    w_lz[2] = w_lz[3] && (w_src[11:8] == 4'h0);
    w_lz[1] = w_lz[2] && (w_src[7:4] == 4'h0);
    w_lz[0] = 1'b0;
    w_seg   = w_lz[w_next_idx] ? 7'b1111111 : decode(w_digit);
    w_dp    = ~w_dp_bits[w_next_idx];
  end

  always_ff @(posedge System_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_idx        <= 2'd3;
      r_snap       <= '0;
      r_run        <= 1'b0;
      r_ano        <= 4'b1111;
      r_leds       <= 7'b1111111;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_div_cnt    <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      // No digit-3 slot precedes the very first tick, so no pulse there.
      r_frame_done <= w_load && r_run;
      if (w_tick) begin
        r_idx  <= w_next_idx;
        r_run  <= 1'b1;
        r_ano  <= en ? ~(4'b0001 << w_next_idx) : 4'b1111;
        r_leds <= w_seg;
        r_dp   <= w_dp;
      end
      if (w_load) begin
        r_snap <= {dp_in, digits};
      end
    end
  end

  assign ano        = r_ano;
  assign leds       = r_leds;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan4.sv
// ============================================================================
// tb_seg_scan4 : directed self-checking bench for seg_scan4 (CLK_DIV = 4)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan4;

  localparam int CLK_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_en;
  logic        en;
  logic [3:0]  ano;
  logic [6:0]  leds;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan4 #(.CLK_DIV(CLK_DIV)) dut (
    .System_clk (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_en   (blank_en),
    .en         (en),
    .ano        (ano),
    .leds       (leds),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] e_ano,
                          input logic [6:0] e_leds, input logic e_dp);
    chk({tag, ".ano"},  {3'b000, ano}, {3'b000, e_ano});
    chk({tag, ".leds"}, leds, e_leds);
    chk({tag, ".dp"},   {6'b0, dp}, {6'b0, e_dp});
  endtask

  task automatic chk_fd(input string tag, input logic e_fd);
    chk({tag, ".frame_done"}, {6'b0, frame_done}, {6'b0, e_fd});
  endtask

  initial begin
    rst_n    = 1'b0;
    digits   = 16'h1234;
    dp_in    = 4'b0000;
    blank_en = 1'b0;
    en       = 1'b1;

    // Reset state held across edges
    step(2);
    chk_slot("reset", 4'b1111, SB, 1'b1);
    chk_fd("reset", 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // First frame, edges counted from release
    step(3);
    chk_slot("pre_first", 4'b1111, SB, 1'b1);
    step(1);                                   // E4
    chk_slot("f1_d0", 4'b1110, S4, 1'b1);
    step(4);                                   // E8
    chk_slot("f1_d1", 4'b1101, S3, 1'b1);
    step(4);                                   // E12
    chk_slot("f1_d2", 4'b1011, S2, 1'b1);
    step(4);                                   // E16
    chk_slot("f1_d3", 4'b0111, S1, 1'b1);
    chk_fd("f1_mid", 1'b0);
    step(4);                                   // E20
    chk_fd("f1_end", 1'b1);
    chk_slot("f2_d0", 4'b1110, S4, 1'b1);
    step(1);                                   // E21
    chk_fd("f1_end_plus1", 1'b0);

    // Snapshot coherence: new data while digit 1 is lit
    step(3);                                   // E24
    digits = 16'h5678;
    chk_slot("coh_d1", 4'b1101, S3, 1'b1);
    step(4);                                   // E28
    chk_slot("coh_d2", 4'b1011, S2, 1'b1);
    step(4);                                   // E32
    chk_slot("coh_d3", 4'b0111, S1, 1'b1);
    step(4);                                   // E36
    chk_slot("new_d0", 4'b1110, S8, 1'b1);
    step(4);                                   // E40
    chk_slot("new_d1", 4'b1101, S7, 1'b1);
    step(4);                                   // E44
    chk_slot("new_d2", 4'b1011, S6, 1'b1);
    step(4);                                   // E48
    chk_slot("new_d3", 4'b0111, S5, 1'b1);

    // Leading-zero blanking on 0070
    digits   = 16'h0070;
    blank_en = 1'b1;
    step(4);                                   // E52
    chk_slot("lz70_d0", 4'b1110, S0, 1'b1);
    step(4);                                   // E56
    chk_slot("lz70_d1", 4'b1101, S7, 1'b1);
    step(4);                                   // E60
    chk_slot("lz70_d2", 4'b1011, SB, 1'b1);
    step(4);                                   // E64
    chk_slot("lz70_d3", 4'b0111, SB, 1'b1);

    // All zeros with blanking: only digit 0 lit
    digits = 16'h0000;
    step(4);                                   // E68
    chk_slot("lz0_d0", 4'b1110, S0, 1'b1);
    step(4);                                   // E72
    chk_slot("lz0_d1", 4'b1101, SB, 1'b1);
    step(4);                                   // E76
    chk_slot("lz0_d2", 4'b1011, SB, 1'b1);
    step(4);                                   // E80
    chk_slot("lz0_d3", 4'b0111, SB, 1'b1);

    // Blanking disabled: all four show 0
    blank_en = 1'b0;
    step(4);                                   // E84
    chk_slot("nolz_d0", 4'b1110, S0, 1'b1);
    step(4);                                   // E88
    chk_slot("nolz_d1", 4'b1101, S0, 1'b1);
    step(4);                                   // E92
    chk_slot("nolz_d2", 4'b1011, S0, 1'b1);
    step(4);                                   // E96
    chk_slot("nolz_d3", 4'b0111, S0, 1'b1);

    // Invalid BCD and decimal point
    digits = 16'hA9F0;
    dp_in  = 4'b0100;
    step(4);                                   // E100
    chk_slot("inv_d0", 4'b1110, S0, 1'b1);
    step(4);                                   // E104
    chk_slot("inv_d1", 4'b1101, SB, 1'b1);
    step(4);                                   // E108
    chk_slot("inv_d2", 4'b1011, S9, 1'b0);
    step(4);                                   // E112
    chk_slot("inv_d3", 4'b0111, SB, 1'b1);

    // Enable dropped mid-slot: anodes off from next tick, frames continue
    step(2);                                   // E114
    en = 1'b0;
    chk_slot("en_hold", 4'b0111, SB, 1'b1);
    step(2);                                   // E116
    chk({"en_off_ano"}, {3'b000, ano}, 7'b0001111);
    chk_fd("en_off_f", 1'b1);
    step(1);                                   // E117
    chk_fd("en_off_f_plus1", 1'b0);
    step(3);                                   // E120
    chk({"en_off_ano2"}, {3'b000, ano}, 7'b0001111);
    step(12);                                  // E132
    chk_fd("en_off_f2", 1'b1);
    step(2);                                   // E134
    en = 1'b1;
    step(2);                                   // E136
    chk_slot("en_on_d1", 4'b1101, SB, 1'b1);
    step(4);                                   // E140
    chk_slot("en_on_d2", 4'b1011, S9, 1'b0);

    // Asynchronous reset in the middle of digit 2's slot
    step(1);                                   // E141 + 1
    #2;
    rst_n = 1'b0;
    #1;
    chk_slot("async_rst", 4'b1111, SB, 1'b1);
    chk_fd("async_rst", 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    chk_slot("rst2_pre", 4'b1111, SB, 1'b1);
    step(1);
    chk_slot("rst2_d0", 4'b1110, S0, 1'b1);
    step(4);
    chk_slot("rst2_d1", 4'b1101, SB, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
